// File: rtl/adc_cap_pkg.sv
// Shared definitions for the serial-ADC capture engine: FSM state encoding,
// default timing constants and the system clock frequency shared with the
// capture-trigger stub.
package adc_cap_pkg;

  localparam int CLK_FREQ        = 20000000;
  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_QUIET_TICKS = 8;
  localparam int DEF_DATA_BITS   = 12;
  localparam int DEF_LEAD_BITS   = 4;
  localparam int FRAME_BITS      = DEF_LEAD_BITS + DEF_DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_CLK_LO = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_DONE   = 3'd4,
    ST_QUIET  = 3'd5
  } state_t;

endpackage

// File: rtl/adc_cap_tick.sv
// Loadable 8-bit down-counter. The FSM reloads it on every state entry; the
// expiry strobe marks the last cycle of the current half-period or quiet
// period. A load of N gives N+1 cycles before the strobe.
module adc_cap_tick (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_expire
);

  logic [7:0] r_cnt;

  // Reload on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expire = (r_cnt == 8'd0);

endmodule

// File: rtl/adc_capture.sv
// Serial-ADC capture engine: a falling edge on startCapture runs one 16-clock
// read frame (leading zeros, then data MSB first) and presents the data bits
// with a one-cycle sampleValid strobe.
// Optional build macro ADC_CAPTURE_LEADZERO_CHECK_EN adds a frameErr output
// flagging a frame whose leading bits were not all zero.
// Handshake: sampleValid is a one-cycle strobe with no ready/back-pressure;
// sample is valid in that cycle and held until the next strobe.
module adc_capture
  import adc_cap_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int LEAD_BITS   = DEF_LEAD_BITS,
  parameter int QUIET_TICKS = DEF_QUIET_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startCapture,
  output logic                 adcCsN,
  output logic                 adcSclk,
  input  logic                 adcSdata,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sampleValid,
  output logic                 busy,
  output logic                 overrun,
  output logic [2:0]           dbgState
`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
  ,
  output logic                 frameErr
`endif
);

  localparam int FRAME_W = LEAD_BITS + DATA_BITS;

  state_t               r_state;
  state_t               w_next;
  logic                 r_start_prev;
  logic                 r_entry;
  logic [4:0]           r_bit_cnt;
  logic [FRAME_W-1:0]   r_shift;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_overrun;
  logic [FRAME_W-1:0]   w_shift_nxt;
  logic                 w_start_fall;
  logic                 w_state_chg;
  logic                 w_capture;
  logic                 w_last_bit;
  logic                 w_expire;
  logic [7:0]           w_load_val;

  assign w_start_fall = r_start_prev & ~startCapture;
  assign w_state_chg  = (w_next != r_state);
  // A bit is taken once, in the first cycle of each sclk-high phase.
  assign w_capture    = (r_state == ST_CLK_HI) && r_entry;
  assign w_last_bit   = (r_bit_cnt == 5'(FRAME_W - 1));
  assign w_shift_nxt  = {r_shift[FRAME_W-2:0], adcSdata};

  adc_cap_tick u_tick (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_state_chg),
    .i_load_val (w_load_val),
    .o_expire   (w_expire)
  );

  // State register plus a flag marking the first cycle spent in a state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_next;
      r_entry <= w_state_chg;
    end
  end

  // Next-state logic; the final bit goes straight to DONE so the sample is
  // presented in the cycle right after it is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_fall) w_next = ST_SETUP;
      ST_SETUP:  if (w_expire) w_next = ST_CLK_LO;
      ST_CLK_LO: if (w_expire) w_next = ST_CLK_HI;
      ST_CLK_HI: begin
        if (w_capture && w_last_bit) w_next = ST_DONE;
        else if (w_expire)           w_next = ST_CLK_LO;
      end
      ST_DONE:   w_next = ST_QUIET;
      ST_QUIET:  if (w_expire) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Dwell time of the state being entered, loaded into the tick counter.
  always_comb begin
    w_load_val = 8'd0;
    case (w_next)
      ST_SETUP, ST_CLK_LO, ST_CLK_HI: w_load_val = 8'(CLK_DIV - 1);
      ST_QUIET:                       w_load_val = 8'(QUIET_TICKS - 1);
      default:                        w_load_val = 8'd0;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    adcCsN      = 1'b1;
    adcSclk     = 1'b1;
    sampleValid = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_SETUP, ST_CLK_HI: adcCsN = 1'b0;
      ST_CLK_LO: begin
        adcCsN  = 1'b0;
        adcSclk = 1'b0;
      end
      ST_DONE:   sampleValid = 1'b1;
      default:   ;
    endcase
  end

  // Start-edge history, shift register, bit count, sample and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start_prev <= 1'b1;
      r_bit_cnt    <= 5'd0;
      r_shift      <= '0;
      r_sample     <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_start_prev <= startCapture;
      if (w_start_fall && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if (r_state == ST_IDLE) r_bit_cnt <= 5'd0;
      if (w_capture) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (w_last_bit) r_sample <= w_shift_nxt[DATA_BITS-1:0];
      end
    end
  end

`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
  logic r_frame_err;
  logic w_unused_msb;

  // Leading-bit check, refreshed together with the sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
    end else if (w_capture && w_last_bit) begin
      r_frame_err <= |w_shift_nxt[FRAME_W-1:DATA_BITS];
    end
  end

  assign frameErr     = r_frame_err;
  assign w_unused_msb = r_shift[FRAME_W-1];
`else
  // Leading bits are shifted through but never inspected in this build.
  logic w_unused_lead;
  assign w_unused_lead = ^{r_shift[FRAME_W-1], w_shift_nxt[FRAME_W-1:DATA_BITS]};
`endif

  assign sample   = r_sample;
  assign overrun  = r_overrun;
  assign dbgState = r_state;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: an ADC model shifts a 16-bit frame out on
// adcSclk falling edges; each scenario records frame timing relative to the
// start cycle T and compares it with hand-computed values.
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startCapture = 1'b1;
  logic        adcCsN;
  logic        adcSclk;
  logic        adcSdata = 1'b0;
  logic [11:0] sample;
  logic        sampleValid;
  logic        busy;
  logic        overrun;
  logic [2:0]  dbgState;
`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
  logic        frameErr;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  // clock / reset
  always #25 clk = ~clk;

  adc_capture dut (
    .clk          (clk),
    .reset        (reset),
    .startCapture (startCapture),
    .adcCsN       (adcCsN),
    .adcSclk      (adcSclk),
    .adcSdata     (adcSdata),
    .sample       (sample),
    .sampleValid  (sampleValid),
    .busy         (busy),
    .overrun      (overrun),
    .dbgState     (dbgState)
`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
    ,
    .frameErr     (frameErr)
`endif
  );

  // ADC model: next bit presented on each sclk fall while selected.
  logic [15:0] adc_frame = 16'h0000;
  int          adc_idx   = 0;
  always @(negedge adcSclk or posedge adcCsN) begin
    if (adcCsN === 1'b1) begin
      adc_idx = 0;
    end else if (adc_idx < 16) begin
      adcSdata = adc_frame[15 - adc_idx];
      adc_idx++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-frame observations, cycle numbers relative to start cycle T
  int          o_csn_first, o_csn_last, o_rises, o_rise_bad;
  int          o_valid_n, o_valid_at, o_busy_fall;
  logic        o_busy_at0, o_ovr_a, o_ovr_b;
  logic [11:0] o_valid_sample;
  logic [2:0]  o_valid_state;
  logic [3:0]  o_post_reset;
  logic        o_valid_err;

  // driver: start edge at T, optional release/second edge/reset, observe
  task automatic do_frame(input logic [15:0] frame, input int hold, input int second_at,
                          input int reset_at, input int run_len);
    logic prev_sclk;
    logic prev_busy;
    o_csn_first = -1; o_csn_last = -1; o_rises = 0; o_rise_bad = 0;
    o_valid_n = 0; o_valid_at = -1; o_busy_fall = -1;
    o_valid_sample = 12'h0; o_valid_state = 3'd0; o_valid_err = 1'b0;
    o_busy_at0 = 1'b1; o_ovr_a = 1'b1; o_ovr_b = 1'b0; o_post_reset = 4'h0;
    prev_sclk = 1'b1; prev_busy = 1'b0;
    adc_frame = frame;
    @(posedge clk); #1;
    startCapture = 1'b0;
    for (int i = 0; i <= run_len; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == hold) startCapture = 1'b1;
        if (second_at != 0 && i == second_at) startCapture = 1'b0;
        if (second_at != 0 && i == second_at + 1) startCapture = 1'b1;
        if (reset_at != 0 && i == reset_at) reset = 1'b0;
        if (reset_at != 0 && i == reset_at + 1) reset = 1'b1;
      end
      @(negedge clk);
      if (i == 0) o_busy_at0 = busy;
      if (!adcCsN) begin
        if (o_csn_first < 0) o_csn_first = i;
        o_csn_last = i;
      end
      if (adcSclk && !prev_sclk) begin
        if (i != 9 + 8 * o_rises) o_rise_bad++;
        o_rises++;
      end
      if (sampleValid) begin
        o_valid_n++;
        o_valid_at = i;
        o_valid_sample = sample;
        o_valid_state = dbgState;
`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
        o_valid_err = frameErr;
`endif
      end
      if (prev_busy && !busy) o_busy_fall = i;
      if (second_at != 0 && i == second_at) o_ovr_a = overrun;
      if (second_at != 0 && i == second_at + 1) o_ovr_b = overrun;
      if (reset_at != 0 && i == reset_at + 1) o_post_reset = {adcCsN, adcSclk, busy, overrun};
      prev_sclk = adcSclk;
      prev_busy = busy;
    end
    startCapture = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_csn", adcCsN, 1);
    check_eq("rst_sclk", adcSclk, 1);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_valid", sampleValid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_state", dbgState, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // nominal frame 0000_1010_1100_0011
    do_frame(16'h0AC3, 1, 0, 0, 142);
    check_eq("f1_csn_first", o_csn_first, 1);
    check_eq("f1_csn_last", o_csn_last, 129);
    check_eq("f1_rises", o_rises, 16);
    check_eq("f1_rise_pos", o_rise_bad, 0);
    check_eq("f1_valid_n", o_valid_n, 1);
    check_eq("f1_valid_at", o_valid_at, 130);
    check_eq("f1_sample", o_valid_sample, 12'hAC3);
    check_eq("f1_done_state", o_valid_state, 3'd4);
    check_eq("f1_busy_fall", o_busy_fall, 139);
    check_eq("f1_overrun", overrun, 0);
    check_eq("f1_sample_held", sample, 12'hAC3);

    // all-ones then all-zeros data
    do_frame(16'h0FFF, 1, 0, 0, 142);
    check_eq("f2_sample", o_valid_sample, 12'hFFF);
    check_eq("f2_valid_n", o_valid_n, 1);
    do_frame(16'h0000, 1, 0, 0, 142);
    check_eq("f3_sample", o_valid_sample, 12'h000);
    check_eq("f3_valid_n", o_valid_n, 1);
    check_eq("f3_valid_at", o_valid_at, 130);

    // held start plus a second edge mid-frame
    do_frame(16'h0123, 3, 50, 0, 142);
    check_eq("ov_csn_first", o_csn_first, 1);
    check_eq("ov_valid_n", o_valid_n, 1);
    check_eq("ov_sample", o_valid_sample, 12'h123);
    check_eq("ov_valid_at", o_valid_at, 130);
    check_eq("ov_before", o_ovr_a, 0);
    check_eq("ov_after", o_ovr_b, 1);
    check_eq("ov_sticky", overrun, 1);

    // reset mid-frame aborts
    do_frame(16'h0FFF, 1, 0, 60, 142);
    check_eq("rm_outputs", o_post_reset, 4'b1100);
    check_eq("rm_valid_n", o_valid_n, 0);
    check_eq("rm_sample", sample, 12'h000);
    check_eq("rm_overrun", overrun, 0);

    // back-to-back: second start exactly when busy drops (T+139)
    do_frame(16'h0A5A, 1, 0, 0, 138);
    check_eq("bb1_sample", o_valid_sample, 12'hA5A);
    do_frame(16'h05A5, 1, 0, 0, 142);
    check_eq("bb2_busy_at_start", o_busy_at0, 0);
    check_eq("bb2_csn_first", o_csn_first, 1);
    check_eq("bb2_sample", o_valid_sample, 12'h5A5);
    check_eq("bb2_overrun", overrun, 0);

`ifdef ADC_CAPTURE_LEADZERO_CHECK_EN
    // leading-bit check
    do_frame(16'h4001, 1, 0, 0, 142);
    check_eq("le_sample", o_valid_sample, 12'h001);
    check_eq("le_err", o_valid_err, 1);
    check_eq("le_err_held", frameErr, 1);
    do_frame(16'h0555, 1, 0, 0, 142);
    check_eq("le_clean_sample", o_valid_sample, 12'h555);
    check_eq("le_clean_err", o_valid_err, 0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
